// File: rtl/gray_decoder_scan_display.sv
// Synchronised Gray-to-binary decode for LEDs, shift-add-3 BCD conversion, multiplexed 7-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above digit 0 when all higher digits are zero.
module gray_decoder_scan_display #(
  parameter int WIDTH       = 4,
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      gray_in,
  output logic [WIDTH-1:0]      led,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  overflow,
  output logic                  busy
);
  localparam int BCD_DIGITS = (WIDTH + 2) / 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SR_W       = BCD_W + WIDTH;
  localparam int STEP_W     = $clog2(WIDTH + 1);
  localparam int CNT_W      = $clog2(REFRESH_DIV);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]      bin_dec;
  logic [WIDTH-1:0]      bin_reg;
  logic [WIDTH-1:0]      last_conv;
  state_t                state_q, state_d;
  logic [SR_W-1:0]       sr_q, sr_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [3:0]            digit_q [BCD_DIGITS];
  logic                  overflow_q, ovf_d;
  logic                  capture, load;
  logic [CNT_W-1:0]      refresh_q;
  logic [IDX_W-1:0]      idx_q;
  logic [3:0]            cur_digit;
  logic                  blank;
  logic [6:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  function automatic logic [SR_W-1:0] bcd_step(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] t;
    t = v;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (t[WIDTH+4*d +: 4] >= 4'd5) t[WIDTH+4*d +: 4] = t[WIDTH+4*d +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      bin_reg <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      bin_reg <= bin_dec;
    end
  end

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < WIDTH; i++) bin_dec[i] = ^(sync_q[SYNC_STAGES-1] >> i);
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    step_d  = step_q;
    capture = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bin_reg != last_conv) begin
          state_d = CONVERT;
          sr_d    = {{BCD_W{1'b0}}, bin_reg};
          step_d  = '0;
          capture = 1'b1;
        end
      end
      CONVERT: begin
        sr_d   = bcd_step(sr_q);
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(WIDTH - 1)) state_d = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = 1'b0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (d >= NUM_DIGITS && sr_q[WIDTH+4*d +: 4] != 4'd0) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      step_q     <= '0;
      last_conv  <= '0;
      overflow_q <= 1'b0;
      for (int d = 0; d < BCD_DIGITS; d++) digit_q[d] <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      step_q  <= step_d;
      if (capture) last_conv <= bin_reg;
      if (load) begin
        for (int d = 0; d < BCD_DIGITS; d++) digit_q[d] <= sr_q[WIDTH+4*d +: 4];
        overflow_q <= ovf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      idx_q     <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      refresh_q <= refresh_q + CNT_W'(1);
    end
  end

  // Digits beyond the BCD range read as zero; overflow dashes win over blanking.
  always_comb begin
    cur_digit = '0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (int'(idx_q) == d) cur_digit = digit_q[d];
    end
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx_q != '0);
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (d >= int'(idx_q) && digit_q[d] != 4'd0) blank = 1'b0;
    end
`else
    blank = 1'b0;
`endif
    if (overflow_q)  seg_d = SEG_DASH;
    else if (blank)  seg_d = SEG_BLANK;
    else             seg_d = seg_of(cur_digit);
    an_d = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

  assign led      = bin_reg;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);

endmodule
